// File: rtl/row_frame_collector_pkg.sv
// Shared types and helpers for the row_frame_collector slice.
package row_frame_collector_pkg;

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } buf_state_t;

    // Row index width, kept at least one bit so a single-row frame still has an index.
    function automatic int row_idx_w(input int d1);
        if (d1 <= 1) begin
            return 1;
        end else begin
            return $clog2(d1);
        end
    endfunction

endpackage

// File: rtl/row_frame_buf.sv
// One ping-pong half: a D1_WIDTH x D2_WIDTH frame register plus its EMPTY/FULL state.
module row_frame_buf
    import row_frame_collector_pkg::*;
#(
    parameter int D1_WIDTH = 8,
    parameter int D2_WIDTH = 3,
    parameter int IDX_W    = 3
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               wr_en,
    input  logic [IDX_W-1:0]                   wr_idx,
    input  logic [D2_WIDTH-1:0]                wr_data,
    input  logic [D1_WIDTH-1:0]                zero_mask,
    input  logic                               set_full,
    input  logic                               clr,
    output buf_state_t                         state,
    output logic [D1_WIDTH-1:0][D2_WIDTH-1:0]  frame
);

    logic [D1_WIDTH-1:0][D2_WIDTH-1:0] frame_d;
    logic [D1_WIDTH-1:0][D2_WIDTH-1:0] frame_q;
    buf_state_t                        state_d;
    buf_state_t                        state_q;

    // Next frame contents and occupancy; the zero mask never covers the row written this cycle.
    always_comb begin
        frame_d = frame_q;
        for (int k = 0; k < D1_WIDTH; k++) begin
            if (zero_mask[k]) begin
                frame_d[k] = {D2_WIDTH{1'b0}};
            end else if (wr_en && (wr_idx == IDX_W'(k))) begin
                frame_d[k] = wr_data;
            end else begin
                frame_d[k] = frame_q[k];
            end
        end

        state_d = state_q;
        case (state_q)
            EMPTY: begin
                if (set_full) begin
                    state_d = FULL;
                end else begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (clr) begin
                    state_d = EMPTY;
                end else begin
                    state_d = FULL;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    // Frame and state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_q <= {(D1_WIDTH*D2_WIDTH){1'b0}};
            state_q <= EMPTY;
        end else begin
            frame_q <= frame_d;
            state_q <= state_d;
        end
    end

    assign state = state_q;
    assign frame = frame_q;

endmodule

// File: rtl/row_frame_collector.sv
// Packs D1_WIDTH rows into a ping-pong double-buffered frame with valid/ready on both sides.
// Optional early-close flush port enabled by defining ROW_FRAME_COLLECTOR_FLUSH_EN.
module row_frame_collector
    import row_frame_collector_pkg::*;
#(
    parameter int D1_WIDTH = 8,
    parameter int D2_WIDTH = 3
) (
    input  logic                               clk,
    input  logic                               rst,
`ifdef ROW_FRAME_COLLECTOR_FLUSH_EN
    input  logic                               flush,
`endif
    input  logic [D2_WIDTH-1:0]                in_data,
    input  logic                               in_valid,
    output logic                               in_ready,
    output logic [D1_WIDTH-1:0][D2_WIDTH-1:0]  out_frame,
    output logic                               out_valid,
    input  logic                               out_ready
);

    localparam int               IDX_W    = row_idx_w(D1_WIDTH);
    localparam int               CNT_W    = IDX_W + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(D1_WIDTH - 1);

    logic [IDX_W-1:0] idx_d, idx_q;
    logic             wr_sel_d, wr_sel_q;
    logic             rd_sel_d, rd_sel_q;

    logic                              accept_s;
    logic                              pop_s;
    logic                              complete_s;
    logic                              flush_fire_s;
    logic [D1_WIDTH-1:0]               zero_mask_s;
    logic [1:0]                        wr_en_s;
    logic [1:0]                        set_full_s;
    logic [1:0]                        clr_s;
    logic [D1_WIDTH-1:0]               buf_mask_s  [2];
    buf_state_t                        buf_state_s [2];
    logic [D1_WIDTH-1:0][D2_WIDTH-1:0] buf_frame_s [2];

    // Handshake outputs are pure muxes of registered buffer state.
    assign in_ready  = (buf_state_s[wr_sel_q] == EMPTY);
    assign out_valid = (buf_state_s[rd_sel_q] == FULL);
    assign out_frame = buf_frame_s[rd_sel_q];
    assign accept_s  = in_valid && in_ready;
    assign pop_s     = out_valid && out_ready;

`ifdef ROW_FRAME_COLLECTOR_FLUSH_EN
    logic [CNT_W-1:0] fill_start_s;

    // A row accepted alongside flush lands first, so zero-filling starts just past it.
    always_comb begin
        fill_start_s = accept_s ? ({1'b0, idx_q} + CNT_W'(1)) : {1'b0, idx_q};
        if (flush && in_ready && (accept_s || (idx_q != {IDX_W{1'b0}}))) begin
            flush_fire_s = 1'b1;
        end else begin
            flush_fire_s = 1'b0;
        end
        for (int k = 0; k < D1_WIDTH; k++) begin
            zero_mask_s[k] = flush_fire_s && (CNT_W'(k) >= fill_start_s);
        end
    end
`else
    assign flush_fire_s = 1'b0;
    assign zero_mask_s  = {D1_WIDTH{1'b0}};
`endif

    // Frame completion, index/pointer advance and per-buffer control steering.
    always_comb begin
        complete_s = (accept_s && (idx_q == LAST_IDX)) || flush_fire_s;

        if (complete_s) begin
            idx_d = {IDX_W{1'b0}};
        end else if (accept_s) begin
            idx_d = idx_q + IDX_W'(1);
        end else begin
            idx_d = idx_q;
        end

        wr_sel_d = complete_s ? ~wr_sel_q : wr_sel_q;
        rd_sel_d = pop_s ? ~rd_sel_q : rd_sel_q;

        for (int b = 0; b < 2; b++) begin
            wr_en_s[b]    = accept_s && (wr_sel_q == b[0]);
            set_full_s[b] = complete_s && (wr_sel_q == b[0]);
            clr_s[b]      = pop_s && (rd_sel_q == b[0]);
            buf_mask_s[b] = (wr_sel_q == b[0]) ? zero_mask_s : {D1_WIDTH{1'b0}};
        end
    end

    // Row index and ping-pong pointers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q    <= {IDX_W{1'b0}};
            wr_sel_q <= 1'b0;
            rd_sel_q <= 1'b0;
        end else begin
            idx_q    <= idx_d;
            wr_sel_q <= wr_sel_d;
            rd_sel_q <= rd_sel_d;
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_buf
        row_frame_buf #(
            .D1_WIDTH (D1_WIDTH),
            .D2_WIDTH (D2_WIDTH),
            .IDX_W    (IDX_W)
        ) u_buf (
            .clk       (clk),
            .rst       (rst),
            .wr_en     (wr_en_s[b]),
            .wr_idx    (idx_q),
            .wr_data   (in_data),
            .zero_mask (buf_mask_s[b]),
            .set_full  (set_full_s[b]),
            .clr       (clr_s[b]),
            .state     (buf_state_s[b]),
            .frame     (buf_frame_s[b])
        );
    end

endmodule

// File: tb/tb_row_frame_collector.sv
// Directed self-checking bench for row_frame_collector (8x3 instance and 1x4 instance).
module tb_row_frame_collector;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic             flush = 1'b0;
    logic [2:0]       in_data = 3'd0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [7:0][2:0]  out_frame;
    logic             out_valid;
    logic             out_ready = 1'b0;

    logic             d1_flush = 1'b0;
    logic [3:0]       d1_in_data = 4'd0;
    logic             d1_in_valid = 1'b0;
    logic             d1_in_ready;
    logic [0:0][3:0]  d1_out_frame;
    logic             d1_out_valid;
    logic             d1_out_ready = 1'b0;

    int checks = 0;
    int errors = 0;

    row_frame_collector #(.D1_WIDTH(8), .D2_WIDTH(3)) dut8 (
        .clk       (clk),
        .rst       (rst),
`ifdef ROW_FRAME_COLLECTOR_FLUSH_EN
        .flush     (flush),
`endif
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_frame (out_frame),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    row_frame_collector #(.D1_WIDTH(1), .D2_WIDTH(4)) dut1 (
        .clk       (clk),
        .rst       (rst),
`ifdef ROW_FRAME_COLLECTOR_FLUSH_EN
        .flush     (d1_flush),
`endif
        .in_data   (d1_in_data),
        .in_valid  (d1_in_valid),
        .in_ready  (d1_in_ready),
        .out_frame (d1_out_frame),
        .out_valid (d1_out_valid),
        .out_ready (d1_out_ready)
    );

    task automatic do_reset();
        in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
        d1_in_valid = 1'b0; d1_out_ready = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic send_row(input logic [2:0] d);
        in_data = d; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (out_frame !== 24'd0) begin errors++; $display("FAIL reset_out_frame: got %h expected 000000", out_frame); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        checks++; if (d1_out_valid !== 1'b0 || d1_in_ready !== 1'b1) begin errors++; $display("FAIL reset_d1: got valid=%b ready=%b expected valid=0 ready=1", d1_out_valid, d1_in_ready); end
    endtask

    task automatic test_stream();
        do_reset();
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            in_data = 3'(k); in_valid = 1'b1;
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready row %0d: got %b expected 1", k, in_ready); end
            @(posedge clk); #1;
            if (k < 7) begin
                checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_early_valid row %0d: got %b expected 0", k, out_valid); end
            end
        end
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stream_valid: got %b expected 1", out_valid); end
        checks++; if (out_frame !== 24'o76543210) begin errors++; $display("FAIL stream_frame: got %o expected 76543210", out_frame); end
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_popped: got %b expected 0", out_valid); end
    endtask

    task automatic test_both_full();
        do_reset();
        out_ready = 1'b0;
        for (int k = 0; k < 16; k++) begin
            in_data = (k < 8) ? 3'(k) : 3'(15 - k); in_valid = 1'b1;
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL full_in_ready row %0d: got %b expected 1", k, in_ready); end
            @(posedge clk); #1;
        end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL full_valid: got %b expected 1", out_valid); end
        checks++; if (out_frame !== 24'o76543210) begin errors++; $display("FAIL full_frame1: got %o expected 76543210", out_frame); end
        in_data = 3'd5; in_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_blocked cycle %0d: got %b expected 0", c, in_ready); end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL full_ready_back: got %b expected 1", in_ready); end
        checks++; if (out_valid !== 1'b1 || out_frame !== 24'o01234567) begin errors++; $display("FAIL full_frame2: got valid=%b %o expected valid=1 01234567", out_valid, out_frame); end
        @(posedge clk); #1;
        for (int k = 1; k < 8; k++) begin
            in_data = 3'(k);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_refilled: got %b expected 0", in_ready); end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_frame !== 24'o76543215) begin errors++; $display("FAIL full_frame3: got valid=%b %o expected valid=1 76543215", out_valid, out_frame); end
    endtask

    task automatic test_stability();
        do_reset();
        out_ready = 1'b0;
        for (int k = 0; k < 8; k++) send_row(3'(k * 3));
        in_data = 3'd7; in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            checks++; if (out_valid !== 1'b1 || out_frame !== 24'o52741630) begin errors++; $display("FAIL stable cycle %0d: got valid=%b %o expected valid=1 52741630", c, out_valid, out_frame); end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_frame !== 24'o77777777) begin errors++; $display("FAIL stable_next: got valid=%b %o expected valid=1 77777777", out_valid, out_frame); end
    endtask

    task automatic test_reset_mid_frame();
        do_reset();
        out_ready = 1'b0;
        for (int k = 0; k < 8; k++) send_row(3'd6);
        for (int k = 0; k < 5; k++) send_row(3'd2);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL midrst_pending: got %b expected 1", out_valid); end
        #2 rst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL midrst_async: got valid=%b ready=%b expected valid=0 ready=1", out_valid, in_ready); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        for (int k = 0; k < 8; k++) send_row(3'b101);
        checks++; if (out_valid !== 1'b1 || out_frame !== 24'o55555555) begin errors++; $display("FAIL midrst_frame: got valid=%b %o expected valid=1 55555555", out_valid, out_frame); end
    endtask

    task automatic test_d1_scoreboard();
        logic [3:0] q[$];
        logic [3:0] exp_w;
        int sent = 0;
        int got = 0;
        int cyc = 0;
        logic acc;
        logic pop;
        do_reset();
        d1_in_valid = 1'b1;
        while (sent < 100 && cyc < 1000) begin
            d1_out_ready = (cyc < 20) ? 1'b1 : ((cyc % 2) == 0);
            d1_in_data = 4'(sent);
            acc = d1_in_valid && d1_in_ready;
            pop = d1_out_valid && d1_out_ready;
            if (cyc < 20) begin
                checks++; if (d1_in_ready !== 1'b1) begin errors++; $display("FAIL d1_throughput cycle %0d: got %b expected 1", cyc, d1_in_ready); end
            end
            if (pop) begin
                exp_w = (q.size() > 0) ? q.pop_front() : 4'hx;
                checks++; if (d1_out_frame[0] !== exp_w) begin errors++; $display("FAIL d1_word %0d: got %h expected %h", got, d1_out_frame[0], exp_w); end
                got++;
            end
            if (acc) begin
                q.push_back(d1_in_data);
                sent++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        d1_in_valid = 1'b0;
        d1_out_ready = 1'b1;
        for (int c = 0; c < 10 && q.size() > 0; c++) begin
            if (d1_out_valid) begin
                exp_w = q.pop_front();
                checks++; if (d1_out_frame[0] !== exp_w) begin errors++; $display("FAIL d1_drain %0d: got %h expected %h", got, d1_out_frame[0], exp_w); end
                got++;
            end
            @(posedge clk); #1;
        end
        d1_out_ready = 1'b0;
        checks++; if (sent != 100 || got != 100) begin errors++; $display("FAIL d1_count: got sent=%0d popped=%0d expected 100/100", sent, got); end
        checks++; if (d1_out_valid !== 1'b0) begin errors++; $display("FAIL d1_dup: got valid=%b expected 0", d1_out_valid); end
    endtask

`ifdef ROW_FRAME_COLLECTOR_FLUSH_EN
    task automatic test_flush();
        do_reset();
        out_ready = 1'b0;
        send_row(3'd1); send_row(3'd2); send_row(3'd3);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_frame !== 24'o00000321) begin errors++; $display("FAIL flush_frame: got valid=%b %o expected valid=1 00000321", out_valid, out_frame); end
        for (int k = 0; k < 8; k++) send_row(3'(k));
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_frame !== 24'o76543210) begin errors++; $display("FAIL flush_index_restart: got valid=%b %o expected valid=1 76543210", out_valid, out_frame); end
    endtask
`endif

    initial begin
        test_reset();
        test_stream();
        test_both_full();
        test_stability();
        test_reset_mid_frame();
        test_d1_scoreboard();
`ifdef ROW_FRAME_COLLECTOR_FLUSH_EN
        test_flush();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/row_frame_collector.md
Name: row_frame_collector

Overview:
- Upstream companion of the combinational dimension-reversal stage.
- Accepts a stream of D2_WIDTH-bit rows on a valid/ready handshake and packs D1_WIDTH consecutive rows into one [D1_WIDTH-1:0][D2_WIDTH-1:0] frame.
- Presents the frame on a valid/ready output, so the transposer can consume it as a whole.
- Double-buffered (ping-pong), so row intake continues while a completed frame waits downstream.

Parameters:
- D1_WIDTH, 8, rows per frame (first dimension of out_frame); legal range ≥1.
- D2_WIDTH, 3, bits per row (second dimension); legal range ≥1.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  asynchronous active-high reset.
- in_data  input  D2_WIDTH  row word.
- in_valid  input  1  row word valid.
- in_ready  output  1  collector can accept a row this cycle.
- out_frame  output  [D1_WIDTH-1:0][D2_WIDTH-1:0]  completed frame; row k at out_frame[k].
- out_valid  output  1  out_frame holds a complete frame.
- out_ready  input  1  downstream accepts out_frame this cycle.

Behaviour:
- Reset (async assert, sync release via clk):
  - both buffers empty and zeroed; row index = 0; wr_sel = 0; rd_sel = 0.
  - out_valid = 0, out_frame = 0, in_ready = 1.
- Row accept: in_valid && in_ready. The word is stored at row index, and the index increments.
- Row ordering: first accepted row of a frame → out_frame[0], last → out_frame[D1_WIDTH-1].
- Frame completion: when the accepted row has index D1_WIDTH-1:
  - index wraps to 0; that buffer is marked FULL; wr_sel toggles.
- in_ready = !FULL[wr_sel]. It is a function of registered state only: no combinational path from out_ready or in_valid.
- Each buffer has two states:
  - EMPTY → FULL on last-row write.
  - FULL → EMPTY on out_valid && out_ready while rd_sel points at it; rd_sel then toggles.
- out_valid = FULL[rd_sel]; out_frame = buffer[rd_sel]. Both are driven from registers (mux of two registered buffers).
- Latency: out_valid rises on the clock edge that writes the last row, i.e. the cycle after the last row handshake.
- Throughput: with out_ready tied high, in_ready stays 1 indefinitely (one row per cycle sustained), including D1_WIDTH = 1.
- Both buffers FULL: in_ready = 0. Rows are not accepted, and in_data is ignored even if in_valid = 1.
- Simultaneous events:
  - The last-row write into one buffer and the pop of the other in the same cycle are both honoured.
  - A pop never affects the buffer being written.
- out_frame must remain stable while out_valid && !out_ready; values change only after a pop.
- A freed buffer keeps stale data until rewritten. Rows are always written in full before FULL is set, so stale data is never exposed.
- Reset mid-frame: the partial frame is discarded, and any pending full frame is dropped (out_valid falls asynchronously).

Optional Feature:
- Macro ROW_FRAME_COLLECTOR_FLUSH_EN.
- Defined:
  - Adds input port flush (1 bit).
  - flush && in_ready with row index > 0 zero-fills rows index..D1_WIDTH-1 and marks the buffer FULL (wr_sel toggles, index → 0), in the same cycle as any in_valid row accepted (that row is included first).
  - flush with index == 0 and no row accepted is a no-op.
- Undefined: no flush port; frames complete only after D1_WIDTH rows.

Decomposition:
- Package row_frame_collector_pkg:
  - typedef enum buf_state_t {EMPTY, FULL}.
  - function clog2-based ROW_IDX_W(D1_WIDTH) helper, floored at 1 bit.
- Sub-module row_frame_buf, instantiated twice. It holds one D1_WIDTH×D2_WIDTH register array, its buf_state_t, write-row and set-full inputs, a clear input, and a frame output.
- The top holds the row index, wr_sel, rd_sel, the handshake logic and the output mux.

Test Plan:
- D1=8, D2=3, out_ready=1: send rows 0..7 = 3'd0..3'd7 back-to-back.
  - out_valid is 1 exactly one cycle after row 7, with out_frame[k] == k.
  - in_ready is never 0.
- out_ready=0: send 16 rows.
  - First frame presented; in_ready drops after row 15 (both FULL).
  - A 17th row held on in_valid is not accepted.
  - out_ready=1 for one cycle: in_ready returns to 1 on the next cycle, and out_frame switches to the second frame.
- Backpressure stability: hold out_ready=0 for 10 cycles with out_valid=1 → out_frame bit-identical across all 10 cycles.
- Reset after 5 of 8 rows, then send 8 rows of 3'b101 → first out_frame is all rows 3'b101, with no remnant of the partial frame.
- D1=1, D2=4, out_ready toggling 1/0 each cycle with continuous in_valid:
  - every accepted word appears exactly once, in order.
  - no loss or duplication over 100 words (scoreboard).
- With ROW_FRAME_COLLECTOR_FLUSH_EN: send 3 rows (1,2,3) then flush → out_frame = {0,0,0,0,0,3,2,1} (rows 7..0), and the row index restarts at 0.
